// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word requests to imem and
// buffers up to FIFO_DEPTH fetches; a flush redirects the PC and drops all
// in-flight/buffered fetches.
// Latency: instruction visible at instr_out the cycle its response arrives
// (response data bypasses into an empty-but-allocated head slot).
// Backpressure: stall holds the head slot; imem_req drops once registered
// occupancy (allocated slots + responses still to discard) reaches FIFO_DEPTH.
//
// Ports:
//   clk, rstn                  clock (rising edge), async active-low reset
//   stall, is_flush            hazard-unit stall, redirect request
//   redirect_pc                new fetch PC when is_flush=1 (low bits ignored)
//   imem_req/addr/gnt          request/grant towards instruction memory
//   imem_rvalid/rdata          in-order response from instruction memory
//   instr_out, PC_out          {instr, PC} pair towards the IF/ID register
//   fetch_valid                instr_out/PC_out carry a real fetch
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h1c000000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h03400000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        is_flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] PC_out,
  output logic        fetch_valid
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]           pc;
  logic [31:0]           slot_pc    [FIFO_DEPTH];
  logic [31:0]           slot_instr [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] slot_filled;
  logic [PW-1:0]         alloc_ptr;
  logic [PW-1:0]         fill_ptr;
  logic [PW-1:0]         head_ptr;
  logic [CW-1:0]         alloc_cnt;
  logic [CW-1:0]         discard_cnt;

  logic [CW:0]           occupancy;
  logic                  grant;
  logic                  drop;
  logic                  fill_en;
  logic                  head_alloc;
  logic                  head_filled;
  logic                  bypass;
  logic                  pop;
  logic [CW-1:0]         filled_cnt;
  logic [CW-1:0]         unfilled_cnt;

  // Responses still owed to flushed requests count against capacity so that
  // they can never be mistaken for fetches from the redirected PC.
  assign occupancy = {1'b0, alloc_cnt} + {1'b0, discard_cnt};

  // rstn gating keeps the request low while reset is held.
  assign imem_req  = rstn && !is_flush && (occupancy < DEPTH_OCC);
  assign imem_addr = pc;

  assign grant   = imem_req && imem_gnt;
  assign drop    = (discard_cnt != '0);
  assign fill_en = imem_rvalid && !drop && !is_flush;

  // Fills are in order, so an allocated-but-unfilled head is always the
  // slot the fill pointer targets.
  assign head_alloc  = (alloc_cnt != '0);
  assign head_filled = head_alloc && slot_filled[head_ptr];
  assign bypass      = head_alloc && !slot_filled[head_ptr] && fill_en;

  always_comb begin
    instr_out   = NOP_INSTR;
    PC_out      = 32'h0;
    fetch_valid = 1'b0;
    if (head_filled) begin
      instr_out   = slot_instr[head_ptr];
      PC_out      = slot_pc[head_ptr];
      fetch_valid = 1'b1;
    end else if (bypass) begin
      instr_out   = imem_rdata;
      PC_out      = slot_pc[head_ptr];
      fetch_valid = 1'b1;
    end
  end

  assign pop = fetch_valid && !stall && !is_flush;

  // Only allocated slots ever carry filled=1, so unfilled = allocated - filled.
  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      filled_cnt = filled_cnt + CW'(slot_filled[i]);
    end
    unfilled_cnt = alloc_cnt - filled_cnt;
  end

  // Slot payload needs no reset: validity lives in alloc_cnt/slot_filled.
  always_ff @(posedge clk) begin
    if (grant) begin
      slot_pc[alloc_ptr] <= pc;
    end
    if (fill_en) begin
      slot_instr[fill_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc          <= RESET_PC;
      slot_filled <= '0;
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      alloc_cnt   <= '0;
      discard_cnt <= '0;
    end else if (is_flush) begin
      pc          <= redirect_pc & 32'hFFFF_FFFC;
      slot_filled <= '0;
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      alloc_cnt   <= '0;
      // Every unfilled slot still has a response on its way; the one arriving
      // now is dropped here and so is not owed any more.
      discard_cnt <= discard_cnt + unfilled_cnt - CW'(imem_rvalid);
    end else begin
      if (grant) begin
        alloc_ptr <= alloc_ptr + PW'(1);
        pc        <= pc + 32'd4;
      end
      if (imem_rvalid && drop) begin
        discard_cnt <= discard_cnt - CW'(1);
      end
      if (fill_en) begin
        slot_filled[fill_ptr] <= 1'b1;
        fill_ptr              <= fill_ptr + PW'(1);
      end
      // Placed after the fill so a bypassed-and-popped slot ends up empty.
      if (pop) begin
        slot_filled[head_ptr] <= 1'b0;
        head_ptr              <= head_ptr + PW'(1);
      end
      alloc_cnt <= alloc_cnt + CW'(grant) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: in-order memory model with per-request latency,
// scoreboard of expected {pc, instr} pushed at grant and popped at output.
// Inputs are driven 1ns after the rising edge, outputs sampled on the falling edge.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam logic [31:0] NOP      = 32'h03400000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall;
  logic        is_flush;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] PC_out;
  logic        fetch_valid;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .stall      (stall),
    .is_flush   (is_flush),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_out  (instr_out),
    .PC_out     (PC_out),
    .fetch_valid(fetch_valid)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
    bit          stale;
  } mem_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    bit          filled;
    int          gcyc;
  } exp_t;

  mem_t        mem_q[$];
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  logic [31:0] key      = 32'h0;
  logic [31:0] model_pc = RESET_PC;
  bit          check_lat = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // One clock cycle: drive memory response, check outputs, advance the model.
  task automatic tick();
    int   stale_n;
    int   occ;
    bit   exp_req;
    bit   exp_valid;
    bit   done;
    exp_t hd;
    exp_t ne;
    mem_t m;

    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].data;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEADBEEF;
    end

    @(negedge clk);
    stale_n = 0;
    foreach (mem_q[i]) if (mem_q[i].stale) stale_n++;
    occ     = exp_q.size() + stale_n;
    exp_req = !is_flush && (occ < DEPTH);
    exp_valid = 1'b0;
    if (exp_q.size() > 0) begin
      if (exp_q[0].filled) exp_valid = 1'b1;
      else if (imem_rvalid && !mem_q[0].stale && !is_flush) exp_valid = 1'b1;
    end

    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, model_pc);
    check("fetch_valid", 32'(fetch_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("PC_out", PC_out, exp_q[0].pc);
      check("instr_out", instr_out, exp_q[0].data);
    end else begin
      check("bubble_instr", instr_out, NOP);
      check("bubble_pc", PC_out, 32'h0);
    end
    check("inflight_le_depth", 32'(mem_q.size() <= DEPTH), 32'd1);

    if (imem_rvalid) begin
      m = mem_q.pop_front();
      if (!m.stale && !is_flush) begin
        done = 1'b0;
        foreach (exp_q[i]) begin
          if (!done && !exp_q[i].filled) begin
            exp_q[i].filled = 1'b1;
            done = 1'b1;
          end
        end
      end
    end

    if (exp_valid && !stall && !is_flush) begin
      hd = exp_q.pop_front();
      if (check_lat) check("latency", 32'(cyc), 32'(hd.gcyc + 1));
    end

    if (exp_req && imem_gnt) begin
      m.data  = model_pc ^ key;
      m.due   = cyc + lat;
      m.stale = 1'b0;
      mem_q.push_back(m);
      ne.pc     = model_pc;
      ne.data   = model_pc ^ key;
      ne.filled = 1'b0;
      ne.gcyc   = cyc;
      exp_q.push_back(ne);
      model_pc = model_pc + 32'd4;
    end

    if (is_flush) begin
      exp_q.delete();
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      model_pc = redirect_pc & 32'hFFFF_FFFC;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rstn        = 1'b0;
    stall       = 1'b0;
    is_flush    = 1'b0;
    redirect_pc = 32'h0;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_instr", instr_out, NOP);
    check("rst_pc", PC_out, 32'h0);
    check("rst_valid", 32'(fetch_valid), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Single-cycle memory returning the PC, then a 3-cycle stall on 1c000004
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      check_lat = (i < 2);
      stall     = (i >= 2 && i < 5);
      tick();
    end
    check_lat = 1'b0;
    stall     = 1'b0;

    // Flush with requests in flight
    key = 32'h5a5a0000;
    lat = 3;
    repeat (2) tick();
    is_flush    = 1'b1;
    redirect_pc = 32'h1c000103;
    tick();
    is_flush = 1'b0;
    repeat (10) tick();

    // Flush coinciding with a response and one unfilled slot
    imem_gnt = 1'b0;
    repeat (6) tick();
    lat      = 2;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    tick();
    is_flush    = 1'b1;
    redirect_pc = 32'h1c000200;
    tick();
    is_flush = 1'b0;
    imem_gnt = 1'b1;
    lat      = 1;
    repeat (6) tick();

    // Variable latency: gnt low two of every three cycles, 3-cycle response
    key = 32'h00ff0000;
    lat = 3;
    for (int i = 0; i < 18; i++) begin
      imem_gnt = (i % 3 == 0);
      tick();
    end
    imem_gnt = 1'b1;

    // Back-to-back flushes, then PC wrap past 32'hFFFFFFFC
    lat = 1;
    is_flush    = 1'b1;
    redirect_pc = 32'h00001000;
    tick();
    redirect_pc = 32'hFFFFFFF8;
    tick();
    is_flush = 1'b0;
    repeat (6) tick();

    // Mid-stream asynchronous reset
    rstn = 1'b0;
    #1;
    check("midrst_instr", instr_out, NOP);
    check("midrst_pc", PC_out, 32'h0);
    check("midrst_valid", 32'(fetch_valid), 32'd0);
    check("midrst_req", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b0;
    exp_q.delete();
    mem_q.delete();
    model_pc = RESET_PC;
    key      = 32'h0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
